// File: rtl/ha_array_product_reducer.sv
// ha_array_product_reducer: serially sums ha_array rows into a saturated product word
module ha_array_product_reducer #(
    parameter int ROWS      = 4,
    parameter int T_W       = 9,
    parameter int B_W       = 7,
    parameter int B_SHIFT   = 2,
    parameter int ROW_SHIFT = 2,
    parameter int OUT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*T_W-1:0]   ha_t,
    input  logic [ROWS*B_W-1:0]   ha_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      product,
    output logic                  ovf
);
    localparam int ACC_W = OUT_W + 2;
    localparam int CW    = ROWS > 1 ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t              state;
    logic [ROWS*T_W-1:0] t_q;
    logic [ROWS*B_W-1:0] b_q;
    logic [ACC_W-1:0]    acc;
    logic [CW-1:0]       cnt;
    logic [T_W-1:0]      t_r;
    logic [B_W-1:0]      b_r;
    logic [ACC_W-1:0]    contrib;
    logic [ACC_W-1:0]    sum;
    logic                accept;
    logic                last;

    assign t_r       = t_q[cnt*T_W +: T_W];
    assign b_r       = b_q[cnt*B_W +: B_W];
    assign contrib   = (ACC_W'(t_r) + (ACC_W'(b_r) << B_SHIFT)) << (ROW_SHIFT*cnt);
    assign sum       = acc + contrib;
    assign last      = cnt == CW'(ROWS-1);
    assign out_valid = state == OUT;
    assign in_ready  = state == IDLE || (state == OUT && out_ready);
    assign accept    = in_valid && in_ready;

    // Capture rows, accumulate one row per cycle, then present the saturated result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            t_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else if (state == ACC) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (last) begin
                state   <= OUT;
                ovf     <= sum[ACC_W-1:OUT_W] != '0;
                product <= sum[ACC_W-1:OUT_W] != '0 ? '1 : sum[OUT_W-1:0];
            end
        end else if (accept) begin
            state <= ACC;
            t_q   <= ha_t;
            b_q   <= ha_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (out_valid && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ha_array_product_reducer.sv
// tb_ha_array_product_reducer: directed checks plus a queue model of expected products
module tb_ha_array_product_reducer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] ha_t = '0;
    logic [27:0] ha_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    localparam logic [35:0] T_ALL = 36'hFFFFFFFFF;
    localparam logic [27:0] B_ALL = 28'hFFFFFFF;
    localparam logic [35:0] T_ROW3 = 36'h1FF << 27;
    localparam logic [27:0] B_ROW3 = 28'h7F << 21;

    ha_array_product_reducer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ha_t(ha_t), .ha_b(ha_b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Exact arithmetic sum of all rows, then saturation: {ovf, product}
    function automatic logic [16:0] model(input logic [35:0] t, input logic [27:0] b);
        longint s = 0;
        for (int r = 0; r < 4; r++)
            s += (longint'((t >> (9*r)) & 36'h1FF) + (longint'((b >> (7*r)) & 28'h7F) * 4)) * (longint'(1) << (2*r));
        return s > 65535 ? {1'b1, 16'hFFFF} : {1'b0, 16'(s)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle-level comparison of every presented product against the model queue
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("no_pending_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("model_product", 32'(product), 32'(exp_q[0][15:0]));
                    chk("model_ovf", 32'(ovf), 32'(exp_q[0][16]));
                    chk("in_ready_in_out", 32'(in_ready), 32'(out_ready));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(ha_t, ha_b));
        end
    end

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 12) begin
            @(posedge clk) #1;
            cyc++;
        end
    endtask

    task automatic run(input string nm, input logic [35:0] t, input logic [27:0] b,
                       input logic [15:0] ep, input logic eo, input bit rel);
        int cyc;
        @(posedge clk) #1;
        ha_t = t; ha_b = b; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        ha_t = 36'({$urandom(), $urandom()});
        ha_b = 28'($urandom());
        wait_out(cyc);
        chk({nm, "_latency"}, 32'(cyc), 32'd4);
        chk({nm, "_product"}, 32'(product), 32'(ep));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk) #1;
            out_ready = 1'b0;
            chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        chk("pin_model_one", 32'(model(36'h1, 28'h0)), 32'h00001);
        chk("pin_model_all", 32'(model(T_ALL, B_ALL)), 32'h1FFFF);
        chk("pin_model_mix", 32'(model(36'h1FF << 9, 28'h7F << 14)), 32'h027BC);

        run("t1", 36'h1, 28'h0, 16'h0001, 1'b0, 1'b1);
        run("t2", 36'h0, 28'h1 << 21, 16'h0100, 1'b0, 1'b1);
        run("t3", T_ALL, B_ALL, 16'hFFFF, 1'b1, 1'b1);
        run("edge_max", T_ROW3 | 36'h13F, B_ROW3, 16'hFFFF, 1'b0, 1'b1);
        run("edge_over", T_ROW3 | 36'h140, B_ROW3, 16'hFFFF, 1'b1, 1'b1);

        run("t4", 36'h1FF << 9, 28'h7F << 14, 16'h27BC, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            ha_t = 36'h5;
            ha_b = 28'h3;
            #1;
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_product", 32'(product), 32'h27BC);
            chk("t5_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk) #1;
        end
        ha_t = 36'h1; ha_b = 28'h0; out_ready = 1'b1;
        #1;
        chk("t5_overlap_ready", 32'(in_ready), 32'd1);
        @(posedge clk) #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_after_valid", 32'(out_valid), 32'd0);
        chk("t5_after_in_ready", 32'(in_ready), 32'd0);
        wait_out(cyc);
        chk("t5_next_latency", 32'(cyc), 32'd4);
        chk("t5_next_product", 32'(product), 32'h0001);
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;

        @(posedge clk) #1;
        ha_t = T_ALL; ha_b = B_ALL; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_product", 32'(product), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk) #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk) #1;
            chk("t6_no_output", 32'(out_valid), 32'd0);
        end
        run("t6_recover", 36'h1, 28'h0, 16'h0001, 1'b0, 1'b1);

        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            ha_t = 36'({$urandom(), $urandom()});
            ha_b = 28'($urandom());
            in_valid = 1'b1;
            #1;
            while (!in_ready && w < 12) begin
                @(posedge clk) #1;
                w++;
            end
            if (w >= 12) chk("b2b_accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk) #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
